// File: rtl/switch_sequencer.sv
// switch_sequencer
//   Plays one entry sequence into a switch-style keypad. The sequence is
//   an optional "times" item followed by five BCD digits. Each item is
//   presented on dat/mode for SETUP_CYC cycles. Then enter is strobed for
//   PULSE_CYC cycles. Then enter is held low for GAP_CYC cycles.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : synchronous reset, ACTIVE HIGH despite the name
//   start      : request one sequence (only honoured in IDLE)
//   send_times : 1 = send the times item before the digits
//   times      : guess-count value for the times item (1..9)
//   guess      : five BCD digits, guess[3:0] sent first
//   dat        : digit/times value for the current item
//   enter      : read-in strobe
//   mode       : 1 = times item, 0 = digit item
//   busy       : sequence in progress (CHECK through the last GAP)
//   done       : one-cycle pulse in the FIN cycle
//   err        : one-cycle pulse when a request is rejected
module switch_sequencer #(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 4,
    parameter int GAP_CYC   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        send_times,
    input  logic [3:0]  times,
    input  logic [19:0] guess,
    output logic [3:0]  dat,
    output logic        enter,
    output logic        mode,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // One phase counter serves all three phases, so it is sized for the
    // longest. It only has to count to MAX_CYC-1, and it always has at
    // least one bit.
    localparam int MAX_CYC = (SETUP_CYC > PULSE_CYC) ?
                             ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC) :
                             ((PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC);
    localparam int CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SETUP,
        S_PULSE,
        S_GAP,
        S_FIN
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    item_q, item_d;          // 0..5
    logic [CW-1:0] cnt_q, cnt_d;
    logic [19:0]   guess_q, guess_d;
    logic [3:0]    times_q, times_d;
    logic          send_times_q, send_times_d;
    logic          bad_q, bad_d;
    logic [3:0]    dat_q, dat_d;
    logic          enter_q, enter_d;
    logic          mode_q, mode_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [2:0]    last_item;
    logic [2:0]    dig_idx;
    logic [19:0]   guess_shift;
    logic [3:0]    item_dat;
    logic          item_mode;
    logic          in_item;

    // A request is rejected if any digit is not BCD. It is also rejected
    // if a times item is requested with a value outside 1..9.
    function automatic logic req_bad(input logic        st,
                                     input logic [3:0]  t,
                                     input logic [19:0] g);
        logic bad;
        bad = st && ((t == 4'd0) || (t > 4'd9));
        for (int i = 0; i < 5; i++) begin
            if (g[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    always_comb begin
        state_d      = state_q;
        item_d       = item_q;
        cnt_d        = cnt_q;
        guess_d      = guess_q;
        times_d      = times_q;
        send_times_d = send_times_q;
        bad_d        = bad_q;

        last_item = send_times_q ? 3'd5 : 3'd4;

        case (state_q)
            S_IDLE: begin
                // Inputs are captured once. The rest of the sequence
                // runs only from the latched copies.
                if (start) begin
                    guess_d      = guess;
                    times_d      = times;
                    send_times_d = send_times;
                    bad_d        = req_bad(send_times, times, guess);
                    state_d      = S_CHECK;
                end
            end
            S_CHECK: begin
                if (bad_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_SETUP;
                    item_d  = 3'd0;
                    cnt_d   = '0;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = S_PULSE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (item_q == last_item) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_SETUP;
                        item_d  = item_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Item payload, taken from the next-state view so that the
        // registered outputs line up with the state they belong to.
        // With a times item in front, the digit index is shifted by one.
        dig_idx     = item_d - {2'b00, send_times_d};
        guess_shift = guess_d >> {dig_idx, 2'b00};
        item_mode   = send_times_d && (item_d == 3'd0);
        item_dat    = item_mode ? times_d : guess_shift[3:0];
        in_item     = (state_d == S_SETUP) || (state_d == S_PULSE) ||
                      (state_d == S_GAP);

        dat_d   = in_item ? item_dat : 4'd0;
        mode_d  = in_item && item_mode;
        enter_d = (state_d == S_PULSE);
        busy_d  = in_item || (state_d == S_CHECK);
        done_d  = (state_d == S_FIN);
        err_d   = (state_d == S_CHECK) && bad_d;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q      <= S_IDLE;
            item_q       <= 3'd0;
            cnt_q        <= '0;
            guess_q      <= 20'd0;
            times_q      <= 4'd0;
            send_times_q <= 1'b0;
            bad_q        <= 1'b0;
            dat_q        <= 4'd0;
            enter_q      <= 1'b0;
            mode_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            item_q       <= item_d;
            cnt_q        <= cnt_d;
            guess_q      <= guess_d;
            times_q      <= times_d;
            send_times_q <= send_times_d;
            bad_q        <= bad_d;
            dat_q        <= dat_d;
            enter_q      <= enter_d;
            mode_q       <= mode_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign dat   = dat_q;
    assign enter = enter_q;
    assign mode  = mode_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: doc/switch_sequencer.md
SWITCH_SEQUENCER -- requirements
Module: switch_sequencer

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2: cycles `dat`/`mode` are held stable before `enter` rises.
REQ-002 SHALL have parameter PULSE_CYC, default 4: cycles `enter` is held high per item.
REQ-003 SHALL have parameter GAP_CYC, default 2: cycles `enter` is held low after each pulse, before the next item.
REQ-004 SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port `rst_n`, input, 1 bit: reset, synchronous and active-high (1 = reset), despite the suffix.
REQ-006 SHALL have port `start`, input, 1 bit: request to transmit one entry sequence.
REQ-007 SHALL have port `send_times`, input, 1 bit: 1 = prefix the sequence with a times item.
REQ-008 SHALL have port `times`, input, 4 bits: guess-count value sent as the times item.
REQ-009 SHALL have port `guess`, input, 20 bits: five BCD digits; guess[3:0] is sent first, guess[19:16] last.
REQ-010 SHALL have port `dat`, output, 4 bits: digit lines (switch1..switch4 order, `dat[3]` = switch1).
REQ-011 SHALL have port `enter`, output, 1 bit: read-in strobe (switch5 role).
REQ-012 SHALL have port `mode`, output, 1 bit: item kind (switch6 role); 1 = times, 0 = digit.
REQ-013 SHALL have port `busy`, output, 1 bit: high while a sequence is in progress.
REQ-014 SHALL have port `done`, output, 1 bit: one-cycle pulse when a sequence completes.
REQ-015 SHALL have port `err`, output, 1 bit: one-cycle pulse when a start request is rejected.

Function
REQ-016 SHALL implement FSM states IDLE, CHECK, SETUP, PULSE, GAP, FIN.
REQ-017 In IDLE with `start`=1, SHALL latch `guess`, `times` and `send_times` and go to CHECK.
- Inputs are sampled once; later input changes do not affect the sequence in progress.
REQ-018 CHECK SHALL reject the request if any latched nibble is >9, or if `send_times`=1 and `times`=0.
- On reject: pulse `err` for 1 cycle, return to IDLE, `enter` never asserted.
REQ-019 CHECK SHALL otherwise go to SETUP with item index 0.
- Item count N = 6 if `send_times`=1, else 5.
- With times: item 0 is the times item (`mode`=1); the remaining items are the digits (`mode`=0).
REQ-020 SETUP SHALL drive `dat`/`mode` for the current item with `enter`=0 for exactly SETUP_CYC cycles.
REQ-021 PULSE SHALL drive `enter`=1 for exactly PULSE_CYC cycles.
REQ-022 GAP SHALL drive `enter`=0 for exactly GAP_CYC cycles.
REQ-023 `dat` and `mode` SHALL remain constant across SETUP, PULSE and GAP of one item.
REQ-024 After GAP, SHALL go to SETUP for the next item; after the last item, SHALL go to FIN.
REQ-025 FIN SHALL pulse `done` for 1 cycle, with `busy`=0 in that same cycle, then go to IDLE.
REQ-026 Timing: `start` sampled at edge 0; CHECK occupies cycle 1; `busy`=1 from cycle 1 through the last GAP cycle.
- First `enter` rise at cycle 2+SETUP_CYC.
- `done` in cycle 2+N*(SETUP_CYC+PULSE_CYC+GAP_CYC).
REQ-027 `start` while not in IDLE SHALL be ignored; no queuing.
REQ-028 `start` held high SHALL launch a new sequence from the IDLE cycle after FIN.
REQ-029 Item and phase counters SHALL never wrap mid-sequence.
- Counter widths SHALL be sized from the parameters (each parameter ≥1).
REQ-030 In IDLE, `dat`=0, `mode`=0, `enter`=0.

Reset
REQ-031 With `rst_n`=1 at a clock edge, SHALL force IDLE and set `dat`=0, `mode`=0, `enter`=0, `busy`=0, `done`=0, `err`=0.
REQ-032 Reset mid-sequence (including during PULSE) SHALL drop `enter` at that edge.
- No `done` is issued for the aborted sequence.
REQ-033 `rst_n` SHALL take priority over `start` at the same edge.

Verification
REQ-034 Scenario 1 (full sequence, default parameters):
- Stimulus: `send_times`=1, `times`=4, `guess`=0x65432, `start` pulse.
- Response: 6 `enter` pulses of 4 cycles each.
- `dat`/`mode` per item: 4/1, 2/0, 3/0, 4/0, 5/0, 6/0.
- `done` at cycle 50.
REQ-035 Scenario 2 (invalid digit):
- Stimulus: `guess` nibble 1 = 0xF.
- Response: `err` pulse in cycle 1, `enter` stays 0, `busy` stays 0 after cycle 1.
REQ-036 Scenario 3 (no times item):
- Stimulus: `send_times`=0, `guess`=0x98765.
- Response: 5 pulses, `mode`=0 throughout, `dat` sequence 5,6,7,8,9, `done` at cycle 42.
REQ-037 Scenario 4 (start while busy):
- Stimulus: assert `start` again during item 2 with different `guess`.
- Response: ignored; original digits complete unchanged.
REQ-038 Scenario 5 (reset mid-pulse):
- Stimulus: `rst_n`=1 during the third PULSE.
- Response: next cycle all outputs 0, no `done`; a fresh `start` afterwards runs the full sequence normally.
REQ-039 Scenario 6 (times = 0):
- Stimulus: `send_times`=1, `times`=0.
- Response: `err` pulse; with `send_times`=0, the same `times`=0 is accepted.
